// File: rtl/cla_iter_add_if.sv
// Handshake bundle for the iterative CLA adder: operand request in, result response out.
interface cla_iter_add_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/cla_iter_add_ctrl.sv
// Sequenced add/sub: one CHUNK-wide carry-lookahead slice reused NCHUNK times,
// with the inter-chunk carry held in a register.

module cla_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W-1:0] p, g;
  logic [W:0]   c;

  assign p = x ^ y;
  assign g = x & y;

  // Flattened lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci
  always_comb begin : la
    logic acc, prop;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      acc  = 1'b0;
      prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = acc | (prop & ci);
    end
  end

  assign s  = p ^ c[W-1:0];
  assign co = c[W];
endmodule

module cla_iter_add_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst,
  cla_iter_add_if.slave io
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("cla_iter_add_ctrl: CHUNK must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;

  logic [NCHUNK-1:0][CHUNK-1:0] a_r, b_r, work, work_nxt;
  logic [CW-1:0]                cnt;
  logic                         carry;
  logic                         a_msb, b_msb;
  logic [WIDTH-1:0]             sum_r;
  logic                         cout_r, ovf_r;

  logic [CHUNK-1:0] slice_s;
  logic             slice_co;
  logic             last;

  assign last = (cnt == CW'(NCHUNK - 1));

  cla_slice #(.W(CHUNK)) u_slice (
    .x  (a_r[cnt]),
    .y  (b_r[cnt]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    work_nxt      = work;
    work_nxt[cnt] = slice_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.in_valid)  state_d = BUSY;
      BUSY:    if (last)         state_d = DONE;
      DONE:    if (io.out_ready) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      work   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (io.in_valid) begin
          // Subtraction becomes a + ~b + ~borrow on the same adder
          a_r   <= io.a;
          b_r   <= io.sub ? ~io.b : io.b;
          carry <= io.cin ^ io.sub;
          cnt   <= '0;
          work  <= '0;
          a_msb <= io.a[WIDTH-1];
          b_msb <= io.b[WIDTH-1] ^ io.sub;
        end
        BUSY: begin
          work  <= work_nxt;
          carry <= slice_co;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum_r  <= work_nxt;
            cout_r <= slice_co;
            // carry into the MSB recovered from its sum bit, xor carry out
            ovf_r  <= a_msb ^ b_msb ^ work_nxt[NCHUNK-1][CHUNK-1] ^ slice_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.busy      = (state_q == BUSY);
  assign io.out_valid = (state_q == DONE);
  assign io.sum       = sum_r;
  assign io.cout      = cout_r;
  assign io.ovf       = ovf_r;
endmodule

// File: tb/tb_cla_iter_add_ctrl.sv
// Directed bench with expected-result scoreboard for the iterative CLA adder.
module tb_cla_iter_add_ctrl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cla_iter_add_if #(.WIDTH(32)) io0 ();
  cla_iter_add_if #(.WIDTH(32)) io1 ();

  cla_iter_add_ctrl #(.WIDTH(32), .CHUNK(4))  dut0 (.clk(clk), .rst(rst), .io(io0));
  cla_iter_add_ctrl #(.WIDTH(32), .CHUNK(32)) dut1 (.clk(clk), .rst(rst), .io(io1));

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    logic [32:0] f;
    if (!sub) f = {1'b0, a} + {1'b0, b} + 33'(cin);
    else      f = {1'b0, a} - {1'b0, b} - 33'(cin);
    r.sum  = f[31:0];
    // borrow-out 1 means cout 0 for subtraction
    r.cout = sub ? ~f[32] : f[32];
    if (!sub) r.ovf = (a[31] == b[31]) && (r.sum[31] != a[31]);
    else      r.ovf = (a[31] != b[31]) && (r.sum[31] != a[31]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input int hold);
    int lat, busy_cnt;
    logic done;
    res_t e;
    @(negedge clk);
    chk("in_ready_idle", 64'(io0.in_ready), 64'd1);
    io0.a = a; io0.b = b; io0.cin = cin; io0.sub = sub; io0.in_valid = 1'b1;
    sb.push_back(model(a, b, cin, sub));
    @(posedge clk);
    lat = 0; busy_cnt = 0; done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      io0.in_valid = 1'b0;
      io0.a = $urandom; io0.b = $urandom;
      io0.cin = 1'($urandom_range(0, 1)); io0.sub = 1'($urandom_range(0, 1));
      if (io0.out_valid) begin done = 1'b1; break; end
      busy_cnt += int'(io0.busy);
      @(posedge clk);
      lat++;
    end
    chk("result_timeout", 64'(done), 64'd1);
    chk("latency", 64'(lat), 64'd8);
    chk("busy_cycles", 64'(busy_cnt), 64'd8);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    chk("sum", 64'(io0.sum), 64'(e.sum));
    chk("cout", 64'(io0.cout), 64'(e.cout));
    chk("ovf", 64'(io0.ovf), 64'(e.ovf));
    for (int h = 0; h < hold; h++) begin
      io0.in_valid = 1'b1;
      io0.a = $urandom; io0.b = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 64'(io0.out_valid), 64'd1);
      chk("hold_in_ready", 64'(io0.in_ready), 64'd0);
      chk("hold_sum", 64'(io0.sum), 64'(e.sum));
      chk("hold_flags", 64'({io0.cout, io0.ovf}), 64'({e.cout, e.ovf}));
    end
    io0.in_valid = 1'b0;
    io0.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io0.out_ready = 1'b0;
    chk("release_valid", 64'(io0.out_valid), 64'd0);
    chk("release_in_ready", 64'(io0.in_ready), 64'd1);
    chk("release_sum_kept", 64'(io0.sum), 64'(e.sum));
  endtask

  initial begin
    res_t e;
    int lat;
    logic done;
    rst = 1'b1;
    io0.in_valid = 0; io0.a = 0; io0.b = 0; io0.cin = 0; io0.sub = 0; io0.out_ready = 0;
    io1.in_valid = 0; io1.a = 0; io1.b = 0; io1.cin = 0; io1.sub = 0; io1.out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(io0.out_valid), 64'd0);
    chk("rst_in_ready", 64'(io0.in_ready), 64'd1);
    chk("rst_busy", 64'(io0.busy), 64'd0);
    chk("rst_sum", 64'(io0.sum), 64'd0);
    chk("rst_flags", 64'({io0.cout, io0.ovf}), 64'd0);
    rst = 1'b0;

    run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
    run_op(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 5);

    // abort mid-operation, after three chunks have been processed
    @(negedge clk);
    io0.a = 32'hFFFF_FFFF; io0.b = 32'h0000_0001; io0.cin = 0; io0.sub = 0; io0.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io0.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_abort_busy", 64'(io0.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(io0.out_valid), 64'd0);
    chk("abort_sum", 64'(io0.sum), 64'd0);
    chk("abort_cout", 64'(io0.cout), 64'd0);
    chk("abort_busy", 64'(io0.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0);
    chk("post_abort_sum", 64'(io0.sum), 64'h2345_6789);

    // single-chunk instance
    @(negedge clk);
    io1.a = 32'hFFFF_FFFF; io1.b = 32'hFFFF_FFFF; io1.cin = 0; io1.sub = 0; io1.in_valid = 1'b1;
    sb.push_back(model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0));
    @(posedge clk);
    lat = 0; done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      io1.in_valid = 1'b0;
      if (io1.out_valid) begin done = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
    chk("w1_timeout", 64'(done), 64'd1);
    chk("w1_latency", 64'(lat), 64'd1);
    if (sb.size() == 0) chk("w1_sb_empty", 64'(sb.size()), 64'd1);
    else begin
      e = sb.pop_front();
      chk("w1_sum", 64'(io1.sum), 64'(e.sum));
      chk("w1_cout", 64'(io1.cout), 64'(e.cout));
      chk("w1_ovf", 64'(io1.ovf), 64'(e.ovf));
    end
    io1.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io1.out_ready = 1'b0;
    chk("w1_release", 64'({io1.out_valid, io1.in_ready}), 64'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
